// File: rtl/complex_add_arbiter_pkg.sv
// complex_pkg: shared types, width helpers and the lane add/sub function for complex_add_arbiter
package complex_pkg;
   localparam int CPLX_W = 16;
   localparam int NUM_REQ_DEF = 4;
   localparam int ID_W = $clog2(NUM_REQ_DEF);
   localparam int MAX_W = 64;
   typedef struct packed {
      logic [CPLX_W-1:0] re;
      logic [CPLX_W-1:0] im;
   } cplx_t;
   // Works on the low w bits; callers truncate the result to their lane width.
   function automatic logic [MAX_W-1:0] sat_add(input logic [MAX_W-1:0] a, input logic [MAX_W-1:0] b,
                                                input logic sub, input logic sat, input int w);
      logic [MAX_W-1:0] bb, s, pmax;
      logic ovf;
      bb = sub ? ~b : b;
      s = a + bb + MAX_W'(sub);
      ovf = (a[w-1] == bb[w-1]) && (s[w-1] != a[w-1]);
      pmax = (MAX_W'(1) << (w-1)) - MAX_W'(1);
      return (sat && ovf) ? (a[w-1] ? ~pmax : pmax) : s;
   endfunction
endpackage

// File: rtl/complex_add_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin grant search starting at ptr, wrapping
// ports: req (request vector), ptr (search start), en (grant enable), gnt (one-hot or zero), idx (first hit)
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IW = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IW-1:0]      ptr,
   input  logic               en,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IW-1:0]      idx
);
   logic found;
   int j;
   always_comb begin
      found = 1'b0;
      idx = '0;
      j = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = (int'(ptr) + k) % NUM_REQ;
         if (!found && req[j]) begin
            found = 1'b1;
            idx = IW'(j);
         end
      end
      gnt = (found && en) ? (NUM_REQ'(1) << idx) : '0;
   end
endmodule

// File: rtl/complex_add_arbiter.sv
// complex_add_arbiter: round-robin shared complex add/sub, 2-stage pipeline, id-tagged responses
// ports: clk, rst_n (async low), req_valid/req_ready/req_sub and packed operands per requester,
//        resp_valid/resp_ready/resp_id/resp_real/resp_imag; COMPLEX_ADD_ARB_SAT_EN enables saturation
module complex_add_arbiter
   import complex_pkg::*;
#(
   parameter int SIZE = 16,
   parameter int FRAC_BITS = 8,
   parameter int NUM_REQ = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ-1:0]        req_sub,
   input  logic [NUM_REQ*SIZE-1:0]   req_a_real,
   input  logic [NUM_REQ*SIZE-1:0]   req_a_imag,
   input  logic [NUM_REQ*SIZE-1:0]   req_b_real,
   input  logic [NUM_REQ*SIZE-1:0]   req_b_imag,
   output logic                      resp_valid,
   input  logic                      resp_ready,
   output logic [$clog2(NUM_REQ)-1:0] resp_id,
   output logic [SIZE-1:0]           resp_real,
   output logic [SIZE-1:0]           resp_imag
);
   localparam int IW = $clog2(NUM_REQ);
`ifdef COMPLEX_ADD_ARB_SAT_EN
   localparam logic SAT = 1'b1;
`else
   localparam logic SAT = 1'b0;
`endif
   typedef struct packed {
      logic [SIZE-1:0] re;
      logic [SIZE-1:0] im;
   } lane_t;
   logic [IW-1:0] ptr, g, s1_id;
   logic [NUM_REQ-1:0] gnt;
   logic s1_valid, s1_sub, s1_ready, s2_ready, hs;
   lane_t s1_a, s1_b, res;
   assign s2_ready = !resp_valid || resp_ready;
   assign s1_ready = !s1_valid || s2_ready;
   rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
      .req(req_valid),
      .ptr(ptr),
      .en(s1_ready && rst_n),
      .gnt(gnt),
      .idx(g)
   );
   assign req_ready = gnt;
   assign hs = |gnt;
   assign res.re = SIZE'(sat_add(MAX_W'(s1_a.re), MAX_W'(s1_b.re), s1_sub, SAT, SIZE));
   assign res.im = SIZE'(sat_add(MAX_W'(s1_a.im), MAX_W'(s1_b.im), s1_sub, SAT, SIZE));
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
         s1_valid <= 1'b0;
         s1_sub <= 1'b0;
         s1_id <= '0;
         s1_a <= '0;
         s1_b <= '0;
         resp_valid <= 1'b0;
         resp_id <= '0;
         resp_real <= '0;
         resp_imag <= '0;
      end else begin
         if (hs) begin
            ptr <= (int'(g) == NUM_REQ-1) ? '0 : g + IW'(1);
            s1_valid <= 1'b1;
            s1_sub <= req_sub[g];
            s1_id <= g;
            s1_a <= '{re: req_a_real[g*SIZE +: SIZE], im: req_a_imag[g*SIZE +: SIZE]};
            s1_b <= '{re: req_b_real[g*SIZE +: SIZE], im: req_b_imag[g*SIZE +: SIZE]};
         end else if (s2_ready) begin
            s1_valid <= 1'b0;
         end
         if (s2_ready) begin
            resp_valid <= s1_valid;
            if (s1_valid) begin
               resp_id <= s1_id;
               resp_real <= res.re;
               resp_imag <= res.im;
            end
         end
      end
   end
endmodule

// File: tb/tb_complex_add_arbiter.sv
// tb_complex_add_arbiter: directed plus random stimulus against a queue-based reference model
module tb_complex_add_arbiter;
   localparam int N = 4;
   localparam int W = 16;
   typedef struct {
      int id;
      int re;
      int im;
      int t;
   } item_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [N-1:0] req_valid = '0, req_ready, req_sub = '0;
   logic [N*W-1:0] req_a_real = '0, req_a_imag = '0, req_b_real = '0, req_b_imag = '0;
   logic resp_valid, resp_ready = 1'b0;
   logic [1:0] resp_id;
   logic [W-1:0] resp_real, resp_imag;
   int checks = 0, failures = 0, cyc = 0, ptr = 0, nresp = 0;
   int last_id, last_re, last_im;
   item_t sb[$];
   always #5 clk = ~clk;
   complex_add_arbiter #(.SIZE(W), .FRAC_BITS(8), .NUM_REQ(N)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_sub(req_sub),
      .req_a_real(req_a_real), .req_a_imag(req_a_imag), .req_b_real(req_b_real), .req_b_imag(req_b_imag),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
      .resp_real(resp_real), .resp_imag(resp_imag)
   );
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   function automatic int lane(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
      int r;
      r = int'($signed(a)) + (sub ? -int'($signed(b)) : int'($signed(b)));
`ifdef COMPLEX_ADD_ARB_SAT_EN
      if (r > 32767) r = 32767;
      if (r < -32768) r = -32768;
`endif
      return r & 32'hFFFF;
   endfunction
   task automatic cycle();
      logic ev, ok, cons;
      logic [N-1:0] er, hs;
      @(negedge clk);
      ev = sb.size() > 0 && cyc >= sb[0].t + 1;
      chk("resp_valid", 32'(resp_valid), 32'(ev));
      if (ev) begin
         chk("resp_id", 32'(resp_id), sb[0].id);
         chk("resp_real", 32'(resp_real), sb[0].re);
         chk("resp_imag", 32'(resp_imag), sb[0].im);
      end
      ok = rst_n && (sb.size() < 2 || resp_ready);
      er = '0;
      for (int k = 0; k < N; k++)
         if (ok && er == '0 && req_valid[(ptr + k) % N]) er[(ptr + k) % N] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(er));
      hs = req_valid & req_ready;
      cons = resp_valid && resp_ready;
      if (cons) begin
         last_id = int'(resp_id);
         last_re = int'(resp_real);
         last_im = int'(resp_imag);
         nresp++;
      end
      @(posedge clk);
      cyc++;
      if (cons && sb.size() > 0) void'(sb.pop_front());
      for (int i = 0; i < N; i++)
         if (hs[i]) begin
            sb.push_back('{i, lane(req_a_real[i*W +: W], req_b_real[i*W +: W], req_sub[i]),
                           lane(req_a_imag[i*W +: W], req_b_imag[i*W +: W], req_sub[i]), cyc});
            ptr = (i + 1) % N;
         end
      #1;
      req_valid = req_valid & ~hs;
   endtask
   task automatic put(input int i, input logic sub, input logic [W-1:0] ar, input logic [W-1:0] ai,
                      input logic [W-1:0] br, input logic [W-1:0] bi);
      req_valid[i] = 1'b1;
      req_sub[i] = sub;
      req_a_real[i*W +: W] = ar;
      req_a_imag[i*W +: W] = ai;
      req_b_real[i*W +: W] = br;
      req_b_imag[i*W +: W] = bi;
   endtask
   function automatic logic [W-1:0] rnd();
      int s;
      s = $urandom_range(0, 7);
      return s == 0 ? 16'h7FFF : s == 1 ? 16'h8000 : 16'($urandom);
   endfunction
   task automatic refill(input logic [N-1:0] mask, input int pct);
      for (int i = 0; i < N; i++)
         if (mask[i] && !req_valid[i] && $urandom_range(0, 99) < pct)
            put(i, 1'($urandom), rnd(), rnd(), rnd(), rnd());
   endtask
   initial begin
      #12;
      chk("rst_resp_valid", 32'(resp_valid), 0);
      chk("rst_resp_data", {resp_real, resp_imag}, 0);
      req_valid = 4'hF;
      #1;
      chk("rst_req_ready", 32'(req_ready), 0);
      req_valid = '0;
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
      resp_ready = 1'b1;
      put(2, 1'b0, 16'h0300, 16'h0200, 16'h0100, 16'h0100);
      repeat (4) cycle();
      chk("t1_id", last_id, 2);
      chk("t1_real", last_re, 32'h0400);
      chk("t1_imag", last_im, 32'h0300);
      put(1, 1'b1, 16'h0100, 16'h0000, 16'h0300, 16'h0100);
      repeat (4) cycle();
      chk("sub_id", last_id, 1);
      chk("sub_real", last_re, 32'hFE00);
      chk("sub_imag", last_im, 32'hFF00);
      put(0, 1'b0, 16'h7FFF, 16'h8000, 16'h0001, 16'hFFFF);
      repeat (4) cycle();
`ifdef COMPLEX_ADD_ARB_SAT_EN
      chk("ovf_add_real", last_re, 32'h7FFF);
      chk("ovf_add_imag", last_im, 32'h8000);
`else
      chk("ovf_add_real", last_re, 32'h8000);
      chk("ovf_add_imag", last_im, 32'h7FFF);
`endif
      put(3, 1'b1, 16'h8000, 16'h7FFF, 16'h0001, 16'hFFFF);
      repeat (4) cycle();
`ifdef COMPLEX_ADD_ARB_SAT_EN
      chk("ovf_sub_real", last_re, 32'h8000);
      chk("ovf_sub_imag", last_im, 32'h7FFF);
`else
      chk("ovf_sub_real", last_re, 32'h7FFF);
      chk("ovf_sub_imag", last_im, 32'h8000);
`endif
      begin
         int n0;
         n0 = nresp;
         repeat (12) begin
            refill(4'hF, 100);
            cycle();
         end
         chk("throughput", nresp - n0, 10);
         req_valid = '0;
         repeat (3) cycle();
      end
      begin
         logic [W*2+1:0] snap;
         refill(4'h7, 100);
         cycle();
         resp_ready = 1'b0;
         repeat (2) begin
            refill(4'h7, 100);
            cycle();
         end
         snap = {resp_id, resp_real, resp_imag};
         repeat (5) begin
            cycle();
            chk("bp_stable", 32'({resp_id, resp_real, resp_imag} ^ snap), 0);
            chk("bp_req_ready", 32'(req_ready), 0);
         end
         resp_ready = 1'b1;
         repeat (8) cycle();
         chk("bp_drained", sb.size(), 0);
      end
      repeat (300) begin
         refill(4'hF, 40);
         resp_ready = $urandom_range(0, 3) != 0;
         cycle();
      end
      resp_ready = 1'b1;
      req_valid = '0;
      repeat (4) cycle();
      chk("rand_drained", sb.size(), 0);
      resp_ready = 1'b0;
      repeat (3) begin
         refill(4'hF, 100);
         cycle();
      end
      refill(4'hF, 100);
      #2 rst_n = 1'b0;
      #1;
      chk("async_resp_valid", 32'(resp_valid), 0);
      chk("async_req_ready", 32'(req_ready), 0);
      sb.delete();
      ptr = 0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      resp_ready = 1'b1;
      refill(4'hF, 100);
      #1;
      chk("post_rst_grant", 32'(req_ready), 32'h1);
      repeat (10) begin
         refill(4'hF, 100);
         cycle();
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
   initial begin
      #200000;
      failures++;
      $display("FAIL timeout got=running exp=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/complex_add_arbiter.md
Name: complex_add_arbiter

Overview:
- Shares one fixed-point complex adder/subtractor datapath (two SIZE-bit lane adders, real and imaginary) between NUM_REQ requesters, e.g. FFT butterfly lanes and the accumulator.
- Round-robin arbitration, valid/ready handshakes on each request port and on the single response port, 2-stage pipeline, throughput of one operation per cycle.
- Each response is tagged with the ID of the requester that issued it.

Parameters:
- SIZE, 16, word width per real/imag component (two's complement)
- FRAC_BITS, 8, fractional bits (Q8.8 default); informational only, since add/sub is scale-invariant
- NUM_REQ, 4, number of requesters (>=2)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester operation valid
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
- req_sub  in  NUM_REQ  1 = a-b, 0 = a+b
- req_a_real, req_a_imag, req_b_real, req_b_imag  in  NUM_REQ*SIZE each  operands; requester i occupies bits [i*SIZE +: SIZE]
- resp_valid  out  1  result valid
- resp_ready  in  1  consumer accept
- resp_id  out  $clog2(NUM_REQ)  originating requester
- resp_real, resp_imag  out  SIZE  result

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - s1_valid=0, resp_valid=0, resp_id/resp_real/resp_imag=0, rr pointer=0.
  - req_ready=0 while rst_n low.
- Pipeline:
  - S1 register holds the granted operands, sub flag and id.
  - The adder is combinational between S1 and the S2 output register (resp_*).
  - s2_ready = !resp_valid || resp_ready.
  - s1_ready = !s1_valid || s2_ready.
- Arbitration:
  - Search req_valid starting at index ptr, wrapping; grant the first asserted.
  - req_ready[g] = s1_ready for the granted index g only; all other bits 0.
  - Handshake when req_valid[g] && req_ready[g]. Then S1 loads operands; ptr <= (g+1) mod NUM_REQ.
  - With no handshake, ptr holds.
- req_ready may depend combinationally on req_valid. Requesters must not make valid depend on ready. Once asserted, valid and operands stay stable until the handshake.
- Latency: handshake in cycle N -> resp_valid in N+2 when there is no backpressure.
- Stalls:
  - resp_valid && !resp_ready: resp_* hold.
  - S1 holds if full; no new grant while s1_ready=0.
  - No data is lost or duplicated.
- Simultaneous S2 drain and S1 refill in the same cycle is legal; full throughput is sustained.
- Arithmetic:
  - resp_real = a_real ± b_real; resp_imag = a_imag ± b_imag.
  - Subtraction = a + ~b + 1.
  - Default on overflow: wrap modulo 2^SIZE. No overflow flag.
- No requests: S1 empties; resp_valid drops after draining.
- Reset mid-operation flushes both stages immediately. In-flight results are discarded and ptr returns to 0.

Optional Feature:
- Macro: COMPLEX_ADD_ARB_SAT_EN
- Defined:
  - Each lane result saturates: positive overflow -> 2^(SIZE-1)-1, negative overflow -> -2^(SIZE-1).
  - Overflow is detected from operand/result sign bits after operand inversion for subtract.
- Undefined: two's-complement wrap. Latency is identical either way.

Decomposition:
- Shared package complex_pkg:
  - typedef cplx_t (packed struct {real, imag} of SIZE bits)
  - function sat_add
  - localparam ID_W = $clog2(NUM_REQ) helper
- One sub-module: rr_arbiter (NUM_REQ parameter).
  - Inputs: req vector, ptr, enable.
  - Outputs: one-hot grant, grant index.
- The two lane adders are instantiated inside complex_add_arbiter.

Test Plan:
- Single request, requester 2: a=(0x0300,0x0200), b=(0x0100,0x0100), add -> after 2 cycles resp_id=2, resp=(0x0400,0x0300).
- All four valid continuously from reset, resp_ready=1 -> grants and resp_id sequence 0,1,2,3,0,…; one response per cycle.
- Subtract from requester 1: a=(0x0100,0x0000), b=(0x0300,0x0100) -> resp=(0xFE00,0xFF00).
- Overflow: a_real=0x7FFF, b_real=0x0001, add -> 0x8000; with COMPLEX_ADD_ARB_SAT_EN defined -> 0x7FFF. a=0x8000 minus 0x0001 -> 0x7FFF wrap / 0x8000 saturated.
- Backpressure: hold resp_ready=0 for 5 cycles with 3 requesters active:
  - resp_* stable
  - S1 holds exactly one op
  - req_ready all 0
  - release -> no loss or duplication; ids remain in round-robin order.
- Assert rst_n=0 with both stages full:
  - resp_valid=0 and req_ready=0 immediately (asynchronously)
  - after release, first grant goes to requester 0 when all are valid.
